dram_bist_ctrl: RTL and testbench

DRAM_BIST_CTRL -- requirements
Module: dram_bist_ctrl

---
 rtl/dram_bist_ctrl.sv | 130 +++++++++++++
 tb/tb_dram_bist_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/dram_bist_ctrl.sv
// DRAM BIST controller: writes a selectable pattern to a 2**ADDR_W x 1 RAM,
// reads every location back, counts mismatches and records the first failing
// address. The pattern is latched when the run starts, and the RAM address,
// data and write-enable outputs are all registered.
module dram_bist_ctrl #(
  parameter int ADDR_W = 9,
  parameter int ERR_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        pat_sel,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_d,
  output logic              ram_we,
  input  logic              ram_o,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_t              state, state_next;
  logic [1:0]          pat, pat_next;
  logic [ADDR_W-1:0]   addr_next, first_next;
  logic                d_next, we_next, pass_next, mismatch;
  logic [ERR_W-1:0]    err_next;

  // Expected data bit for address a under pattern p.
  function automatic logic exp_bit(input logic [1:0] p, input logic [ADDR_W-1:0] a);
    case (p)
      2'b00:   exp_bit = 1'b0;
      2'b01:   exp_bit = 1'b1;
      2'b10:   exp_bit = a[0];
      default: exp_bit = ^a;
    endcase
  endfunction

  // Read-back compare; only ram_o and registers feed it, and it only feeds registers.
  always_comb mismatch = (state == READ) && (ram_o != exp_bit(pat, ram_a));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and next-datapath logic.
  always_comb begin
    state_next = state;
    pat_next   = pat;
    addr_next  = ram_a;
    d_next     = 1'b0;
    we_next    = 1'b0;
    err_next   = err_count;
    first_next = first_err_addr;
    pass_next  = pass;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = WRITE;
          pat_next   = pat_sel;
          addr_next  = '0;
          d_next     = exp_bit(pat_sel, '0);
          we_next    = 1'b1;
          err_next   = '0;
          first_next = '0;
          pass_next  = 1'b0;
        end
      end
      WRITE: begin
        if (ram_a == ADDR_MAX) begin
          state_next = READ;
          addr_next  = '0;
        end else begin
          addr_next  = ram_a + 1'b1;
          d_next     = exp_bit(pat, ram_a + 1'b1);
          we_next    = 1'b1;
        end
      end
      READ: begin
        if (mismatch) begin
          err_next = err_count + 1'b1;
          if (err_count == '0) first_next = ram_a;
        end
        if (ram_a == ADDR_MAX) begin
          state_next = DONE;
          addr_next  = '0;
          pass_next  = (err_next == '0);
        end else begin
          addr_next  = ram_a + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers; reset clears every output immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat            <= 2'b00;
      ram_a          <= '0;
      ram_d          <= 1'b0;
      ram_we         <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      pass           <= 1'b0;
    end else begin
      pat            <= pat_next;
      ram_a          <= addr_next;
      ram_d          <= d_next;
      ram_we         <= we_next;
      err_count      <= err_next;
      first_err_addr <= first_next;
      pass           <= pass_next;
    end
  end

  // Status decoded from the registered state.
  always_comb begin
    busy = (state == WRITE) || (state == READ);
    done = (state == DONE);
  end

endmodule

// File: tb/tb_dram_bist_ctrl.sv
// Bench for dram_bist_ctrl: 512x1 RAM model with fault injection, scoreboard of
// expected run results, directed sequence of runs.
module tb_dram_bist_ctrl;

  localparam int ADDR_W = 9;
  localparam int ERR_W  = 10;
  localparam int DEPTH  = 512;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [1:0]        pat_sel = 2'b00;
  logic [ADDR_W-1:0] ram_a;
  logic              ram_d, ram_we, ram_o;
  logic              busy, done, pass;
  logic [ERR_W-1:0]  err_count;
  logic [ADDR_W-1:0] first_err_addr;

  // 0: ideal RAM, 1: address 5 stuck-at-1, 2: read data tied 0
  int mode = 0;
  logic mem [0:DEPTH-1];
  int wr_count = 0;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {int err; int first; bit ok;} exp_t;
  exp_t sb[$];

  dram_bist_ctrl #(.ADDR_W(ADDR_W), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pat_sel(pat_sel),
    .ram_a(ram_a), .ram_d(ram_d), .ram_we(ram_we), .ram_o(ram_o),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_addr(first_err_addr)
  );

  always #5 clk = ~clk;

  // RAM model: synchronous write, combinational read with optional faults.
  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_a] <= ram_d;
      wr_count   <= wr_count + 1;
    end
  end

  assign ram_o = (mode == 2) ? 1'b0 :
                 ((mode == 1) && (ram_a == 9'd5)) ? 1'b1 : mem[ram_a];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic pat_bit(input logic [1:0] p, input int a);
    logic [ADDR_W-1:0] av;
    av = a[ADDR_W-1:0];
    case (p)
      2'b00:   return 1'b0;
      2'b01:   return 1'b1;
      2'b10:   return av[0];
      default: return ^av;
    endcase
  endfunction

  function automatic exp_t model(input logic [1:0] p, input int m);
    exp_t r;
    logic e, rd;
    r.err = 0; r.first = 0;
    for (int a = 0; a < DEPTH; a++) begin
      e  = pat_bit(p, a);
      rd = (m == 2) ? 1'b0 : ((m == 1) && (a == 5)) ? 1'b1 : e;
      if (rd != e) begin
        if (r.err == 0) r.first = a;
        r.err++;
      end
    end
    r.ok = (r.err == 0);
    return r;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ram_a"}, 32'(ram_a), 0);
    chk({tag, "_ram_d"}, 32'(ram_d), 0);
    chk({tag, "_ram_we"}, 32'(ram_we), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_pass"}, 32'(pass), 0);
    chk({tag, "_err"}, 32'(err_count), 0);
    chk({tag, "_first"}, 32'(first_err_addr), 0);
  endtask

  // One BIST run. start_cyc/pchg_cyc/rst_cyc = cycle after the start edge at which
  // to pulse start, flip pat_sel, or assert reset (0 = never).
  task automatic run(input logic [1:0] p, input int m, input int start_cyc,
                     input int pchg_cyc, input int rst_cyc);
    exp_t e, got;
    int cyc, wr0, wr_snap;
    mode = m;
    sb.push_back(model(p, m));
    pat_sel = p;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wr0 = wr_count;
    cyc = 0;
    while (cyc < 1100) begin
      @(posedge clk); #1;
      cyc++;
      start = (cyc == start_cyc);
      if (cyc == pchg_cyc) pat_sel = ~p;
      if (cyc == 1) begin
        chk("first_busy", 32'(busy), 1);
        chk("first_done", 32'(done), 0);
        chk("first_err_clr", 32'(err_count), 0);
        chk("first_pass_clr", 32'(pass), 0);
      end
      if (rst_cyc != 0 && cyc == rst_cyc) begin
        chk("pre_rst_addr", 32'(ram_a), 200);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        wr_snap = wr_count;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_no_write", 32'(wr_count - wr_snap), 0);
        chk("rst_hold_idle", 32'(busy), 0);
        rst_n = 1'b1;
        void'(sb.pop_back());
        $display("run pat=%b mode=%0d aborted by reset at cycle %0d", p, m, cyc);
        return;
      end
      if (done) break;
    end
    start = 1'b0;
    chk("latency", 32'(cyc), 1024);
    chk("write_count", 32'(wr_count - wr0), DEPTH);
    chk("busy_after", 32'(busy), 0);
    e = sb.pop_front();
    got.err = int'(err_count); got.first = int'(first_err_addr); got.ok = pass;
    chk("err_count", 32'(err_count), 32'(e.err));
    if (e.err != 0) chk("first_err_addr", 32'(first_err_addr), 32'(e.first));
    chk("pass", 32'(pass), 32'(e.ok));
    $display("run pat=%b mode=%0d cycles=%0d err=%0d first=%0d pass=%0b (exp err=%0d first=%0d pass=%0b)",
             p, m, cyc, got.err, got.first, got.ok, e.err, e.first, e.ok);
  endtask

  task automatic check_mem(input logic [1:0] p, input string tag);
    int bad;
    bad = 0;
    for (int a = 0; a < DEPTH; a++)
      if (mem[a] !== pat_bit(p, a)) bad++;
    chk(tag, 32'(bad), 0);
  endtask

  initial begin
    // Reset state, asserted from time 0.
    #2 check_reset_outputs("reset");
    #10 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_busy", 32'(busy), 0);
    chk("idle_done", 32'(done), 0);

    // Ideal RAM, checkerboard: clean pass, contents alternate 0,1.
    run(2'b10, 0, 0, 0, 0);
    check_mem(2'b10, "mem_checker");
    // DONE holds its results for a while.
    repeat (5) @(posedge clk);
    #1;
    chk("done_hold", 32'(done), 1);
    chk("pass_hold", 32'(pass), 1);

    // Address 5 stuck-at-1, all-0 pattern.
    run(2'b00, 1, 0, 0, 0);
    // Read data tied low, parity pattern: 256 errors, first at 1.
    run(2'b11, 2, 0, 0, 0);
    // Back-to-back from a failing DONE, with a stray start and a pat_sel change mid-run.
    run(2'b10, 0, 300, 100, 0);
    check_mem(2'b10, "mem_after_pchg");
    // Reset during READ at address 200.
    run(2'b11, 0, 0, 0, 712);
    // Full clean run after reset.
    run(2'b01, 0, 0, 0, 0);
    check_mem(2'b01, "mem_all_one");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
